fft8_output_reorder: RTL and testbench
======================================

FFT8_OUTPUT_REORDER -- requirements
Module: fft8_output_reorder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the width of each real/imag sample.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port S  input  1  frame-start strobe, high on the cycle carrying input position 0.
REQ-005 SHALL have port D_real  input  DATA_WIDTH  real part of the streamed sample (bit-reversed FFT order).
REQ-006 SHALL have port D_img  input  DATA_WIDTH  imaginary part of the streamed sample.
REQ-007 SHALL have port out_real  output  DATA_WIDTH  real part, natural order.
REQ-008 SHALL have port out_img  output  DATA_WIDTH  imaginary part, natural order.
REQ-009 SHALL have port out_valid  output  1  high while out_real/out_img carry a reordered sample.
REQ-010 SHALL have port out_index  output  3  natural frequency bin index (0..7) of the current output.
REQ-011 SHALL have port out_sof  output  1  high with out_index 0 of each output frame.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse when a frame is aborted by an early S.

Function
REQ-013 SHALL accept one sample per cycle, unconditionally, from the S cycle through 7 following cycles (positions 0..7).
REQ-014 SHALL ignore D_real/D_img when no frame is in progress and S is low.
REQ-015 SHALL store input position k at bank address bitrev3(k) (b2b1b0 -> b0b1b2), e.g. 1->4, 3->6, 6->3.
REQ-016 SHALL use two 8-entry banks (ping-pong); writes fill one bank while the other is read.
REQ-017 SHALL swap banks on the edge that writes position 7, marking the written bank full.
REQ-018 SHALL start read-out so that out_valid rises on the cycle immediately after position 7 is written; latency from position 0 input to index 0 output is 8 cycles.
REQ-019 SHALL output addresses 0..7 in ascending order on 8 consecutive cycles, out_index equal to address, out_valid high for exactly 8 cycles.
REQ-020 SHALL drive out_real/out_img/out_index/out_sof from registers; when out_valid is low they SHALL hold 0.
REQ-021 SHALL support back-to-back frames (S on the cycle after position 7) with continuous out_valid and no lost or repeated samples.
REQ-022 SHALL, when S arrives at positions 1..7 of a frame in progress, discard the partial frame, pulse frame_err for one cycle, and treat the S cycle as position 0 of a new frame in the same bank.
REQ-023 SHALL NOT let a frame abort disturb a read-out already in progress from the other bank.
REQ-024 SHALL use a 3-bit write counter and 3-bit read counter wrapping 7->0; no other counter states.
REQ-025 SHALL implement a read FSM with states IDLE (out_valid=0) and READ (out_valid=1); IDLE->READ on bank-full, READ->IDLE after index 7 unless the other bank is full, otherwise READ continues at index 0 of the new bank.

Reset
REQ-026 SHALL, on rst high, immediately clear all outputs to 0, write/read counters to 0, FSM to IDLE, both banks to empty, bank select to bank 0.
REQ-027 SHALL, on reset mid-frame or mid-read-out, discard all partial and pending data; no output until a new complete frame after rst falls.
REQ-028 SHALL not require bank storage contents to be cleared by reset.

Verification
REQ-029 SHALL pass: one frame, S at position 0, D_real=0..7, D_img=10*D_real -> out_real 0,4,2,6,1,5,3,7 with out_img 0,40,20,60,10,50,30,70, out_index 0..7, out_sof only at index 0.
REQ-030 SHALL pass: two back-to-back frames (second D_real=8..15) -> 16 consecutive out_valid cycles, second frame 8,12,10,14,9,13,11,15.
REQ-031 SHALL pass: S at positions 0 and again at position 4, then 8 samples 20..27 -> frame_err pulse on the second S cycle, output 20,24,22,26,21,25,23,27 only.
REQ-032 SHALL pass: rst asserted during output index 3 -> outputs 0 asynchronously, no remaining indices appear after release.
REQ-033 SHALL pass: no S for 20 cycles with random D_real -> out_valid stays 0, frame_err stays 0.
REQ-034 SHALL pass: S pulse during read-out of frame A that aborts frame B -> frame A output completes intact.

Source files
------------

// File: rtl/fft8_output_reorder.sv
// Converts an 8-point FFT output stream from bit-reversed to natural order
// using two ping-pong banks; a new frame fills one bank while the other drains.
module fft8_output_reorder #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  S,
  input  logic [DATA_WIDTH-1:0] D_real,
  input  logic [DATA_WIDTH-1:0] D_img,
  output logic [DATA_WIDTH-1:0] out_real,
  output logic [DATA_WIDTH-1:0] out_img,
  output logic                  out_valid,
  output logic [2:0]            out_index,
  output logic                  out_sof,
  output logic                  frame_err
);

  typedef enum logic {IDLE, READ} state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] mem_real [2][8];
  logic [DATA_WIDTH-1:0] mem_img  [2][8];

  logic       wr_active;
  logic       wr_bank;
  logic [2:0] wr_cnt;
  logic       rd_bank;
  logic [2:0] rd_cnt;
  logic [1:0] full;

  logic       wr_en;
  logic       done_now;
  logic [2:0] wr_pos;
  logic [2:0] wr_addr;
  logic [1:0] set_mask;
  logic [1:0] clr_mask;
  logic [1:0] full_eff;
  logic       go_read;
  logic       nxt_bank;
  logic [2:0] nxt_addr;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  // An S while a frame is open restarts the frame in the same bank.
  assign frame_err = S & wr_active;

  always_comb begin
    wr_en    = S | wr_active;
    wr_pos   = S ? '0 : wr_cnt;
    wr_addr  = bitrev3(wr_pos);
    done_now = wr_active & ~S & (wr_cnt == 3'd7);
    set_mask = done_now ? (2'b01 << wr_bank) : '0;
  end

  // A bank completing on this edge counts as full, so read-out starts
  // with no bubble after position 7 and back-to-back frames stay contiguous.
  always_comb begin
    full_eff = full | set_mask;
    go_read  = 1'b0;
    nxt_bank = rd_bank;
    nxt_addr = '0;
    clr_mask = '0;
    unique case (state)
      IDLE: begin
        if (|full_eff) begin
          go_read  = 1'b1;
          nxt_bank = full_eff[~rd_bank] ? ~rd_bank : rd_bank;
          clr_mask = 2'b01 << nxt_bank;
        end
      end
      READ: begin
        if (rd_cnt != 3'd7) begin
          go_read  = 1'b1;
          nxt_addr = rd_cnt + 3'd1;
        end else if (full_eff[~rd_bank]) begin
          go_read  = 1'b1;
          nxt_bank = ~rd_bank;
          clr_mask = 2'b01 << nxt_bank;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_real[wr_bank][wr_addr] <= D_real;
      mem_img[wr_bank][wr_addr]  <= D_img;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_active <= 1'b0;
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      full      <= '0;
      state     <= IDLE;
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_real  <= '0;
      out_img   <= '0;
      out_index <= '0;
      out_sof   <= 1'b0;
    end else begin
      if (S) begin
        wr_active <= 1'b1;
        wr_cnt    <= 3'd1;
      end else if (wr_active) begin
        wr_cnt <= wr_cnt + 3'd1;
        if (wr_cnt == 3'd7) begin
          wr_active <= 1'b0;
          wr_bank   <= ~wr_bank;
        end
      end

      full  <= (full | set_mask) & ~clr_mask;
      state <= go_read ? READ : IDLE;

      if (go_read) begin
        rd_bank   <= nxt_bank;
        rd_cnt    <= nxt_addr;
        out_valid <= 1'b1;
        out_real  <= mem_real[nxt_bank][nxt_addr];
        out_img   <= mem_img[nxt_bank][nxt_addr];
        out_index <= nxt_addr;
        out_sof   <= (nxt_addr == 3'd0);
      end else begin
        rd_cnt    <= '0;
        out_valid <= 1'b0;
        out_real  <= '0;
        out_img   <= '0;
        out_index <= '0;
        out_sof   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft8_output_reorder.sv
// Randomized and directed bench for fft8_output_reorder against a cycle-indexed
// reference of when each natural-order sample must appear.
module tb_fft8_output_reorder;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          S;
  logic [DW-1:0] D_real;
  logic [DW-1:0] D_img;
  logic [DW-1:0] out_real;
  logic [DW-1:0] out_img;
  logic          out_valid;
  logic [2:0]    out_index;
  logic          out_sof;
  logic          frame_err;

  fft8_output_reorder #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .S(S), .D_real(D_real), .D_img(D_img),
    .out_real(out_real), .out_img(out_img), .out_valid(out_valid),
    .out_index(out_index), .out_sof(out_sof), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference: collect a frame in arrival order, then schedule its
  // natural-order samples onto absolute output cycles.
  bit            in_frame = 1'b0;
  int            pos = 0;
  logic [DW-1:0] fr_r [8];
  logic [DW-1:0] fr_i [8];
  logic [DW-1:0] exp_r [int];
  logic [DW-1:0] exp_i [int];
  int            exp_n [int];
  int            busy_until = 0;

  function automatic int bitrev(input int n);
    return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic check_out();
    if (exp_r.exists(cyc)) begin
      check("out_valid", 64'(out_valid), 64'(1));
      check("out_real",  64'(out_real),  64'(exp_r[cyc]));
      check("out_img",   64'(out_img),   64'(exp_i[cyc]));
      check("out_index", 64'(out_index), 64'(exp_n[cyc]));
      check("out_sof",   64'(out_sof),   64'(exp_n[cyc] == 0));
    end else begin
      check("idle_valid", 64'(out_valid), 64'(0));
      check("idle_real",  64'(out_real),  64'(0));
      check("idle_img",   64'(out_img),   64'(0));
      check("idle_index", 64'(out_index), 64'(0));
      check("idle_sof",   64'(out_sof),   64'(0));
    end
  endtask

  task automatic step(input bit s, input logic [DW-1:0] dr, input logic [DW-1:0] di);
    bit err_exp;
    int start;
    err_exp = 1'b0;
    if (s) begin
      err_exp  = in_frame;
      in_frame = 1'b1;
      pos      = 0;
    end
    if (in_frame) begin
      fr_r[pos] = dr;
      fr_i[pos] = di;
      if (pos == 7) begin
        start = (cyc + 1 > busy_until) ? cyc + 1 : busy_until;
        for (int n = 0; n < 8; n++) begin
          exp_r[start + n] = fr_r[bitrev(n)];
          exp_i[start + n] = fr_i[bitrev(n)];
          exp_n[start + n] = n;
        end
        busy_until = start + 8;
        in_frame   = 1'b0;
      end else begin
        pos++;
      end
    end
    S      = s;
    D_real = dr;
    D_img  = di;
    #1;
    check("frame_err", 64'(frame_err), 64'(err_exp));
    @(posedge clk);
    #1;
    cyc++;
    check_out();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, DW'($urandom), DW'($urandom));
  endtask

  task automatic reset_pulse();
    S   = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_real",  64'(out_real),  64'(0));
    check("rst_img",   64'(out_img),   64'(0));
    check("rst_index", 64'(out_index), 64'(0));
    check("rst_sof",   64'(out_sof),   64'(0));
    check("rst_err",   64'(frame_err), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    in_frame = 1'b0;
    exp_r.delete();
    exp_i.delete();
    exp_n.delete();
    busy_until = 0;
  endtask

  initial begin
    rst    = 1'b0;
    S      = 1'b0;
    D_real = '0;
    D_img  = '0;
    #2;
    reset_pulse();

    // No S: random data must never produce output or errors.
    idle(20);

    // Single frame 0..7, imag = 10 * real.
    for (int k = 0; k < 8; k++) step(k == 0, DW'(k), DW'(10 * k));
    idle(10);

    // Back-to-back frames 0..7 then 8..15.
    for (int k = 0; k < 16; k++) step(k % 8 == 0, DW'(k), DW'(10 * k));
    idle(10);

    // Abort at position 4, then a clean frame 20..27.
    for (int k = 0; k < 4; k++) step(k == 0, DW'(90 + k), DW'(190 + k));
    for (int k = 0; k < 8; k++) step(k == 0, DW'(20 + k), DW'(120 + k));
    idle(10);

    // Frame A drains while frame B is aborted and replaced by frame C.
    for (int k = 0; k < 8; k++) step(k == 0, DW'(100 + k), DW'(1100 + k));
    idle(2);
    for (int k = 0; k < 3; k++) step(k == 0, DW'(200 + k), DW'(1200 + k));
    for (int k = 0; k < 8; k++) step(k == 0, DW'(300 + k), DW'(1300 + k));
    idle(10);

    // Reset while index 3 is on the outputs; nothing may follow.
    for (int k = 0; k < 8; k++) step(k == 0, DW'(400 + k), DW'(1400 + k));
    idle(3);
    check("pre_rst_index", 64'(out_index), 64'(3));
    reset_pulse();
    idle(12);

    // Reset in the middle of an incoming frame.
    for (int k = 0; k < 5; k++) step(k == 0, DW'(500 + k), DW'(1500 + k));
    reset_pulse();
    for (int k = 0; k < 3; k++) step(1'b0, DW'(505 + k), DW'(1505 + k));
    idle(10);

    // Random S placement and data.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 6) == 0, DW'($urandom), DW'($urandom));
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
